// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper: preamble insertion plus BPSK/QPSK mapping with SPS-sample symbol hold.
// Rev 1.0
`default_nettype none

module psk_symbol_mapper #(
  parameter int O_WIDTH = 12,
  parameter int AMP     = 1024,
  parameter int SPS     = 16,
  parameter int PRE_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                bit_data,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  input  logic                      bpsk_mode,
  output logic signed [O_WIDTH-1:0] DAC_I,
  output logic signed [O_WIDTH-1:0] DAC_Q,
  output logic                      is_bpsk,
  output logic                      sym_strobe,
  output logic                      busy
);

  localparam int c_samp_w = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int c_pre_w  = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [c_samp_w-1:0]       c_samp_last = c_samp_w'(SPS - 1);
  localparam logic [c_pre_w-1:0]        c_pre_last  = c_pre_w'(PRE_LEN - 1);
  localparam logic signed [O_WIDTH-1:0] c_pos       = O_WIDTH'(AMP);
  localparam logic signed [O_WIDTH-1:0] c_neg       = O_WIDTH'(-AMP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                      state_q;
  logic [c_samp_w-1:0]         samp_cnt_q;
  logic [c_pre_w-1:0]          pre_cnt_q;
  logic                        mode_q;
  logic signed [O_WIDTH-1:0]   dac_i_q;
  logic signed [O_WIDTH-1:0]   dac_q_q;
  logic                        is_bpsk_q;
  logic                        sym_strobe_q;
  logic                        busy_q;

  logic                        w_boundary;
  logic signed [O_WIDTH-1:0]   w_next_pre;

  function automatic logic signed [O_WIDTH-1:0] map_bit(input logic b);
    return b ? c_neg : c_pos;
  endfunction

  assign w_boundary = (samp_cnt_q == c_samp_last);
  assign bit_ready  = w_boundary &&
                      ((state_q == S_DATA) || ((state_q == S_PRE) && (pre_cnt_q == c_pre_last)));
  // Preamble alternates sign; the symbol after an even index is negative.
  assign w_next_pre = pre_cnt_q[0] ? c_pos : c_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      samp_cnt_q   <= '0;
      pre_cnt_q    <= '0;
      mode_q       <= 1'b1;
      dac_i_q      <= '0;
      dac_q_q      <= '0;
      is_bpsk_q    <= 1'b1;
      sym_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sym_strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          is_bpsk_q <= bpsk_mode;
          if (bit_valid) begin
            state_q      <= S_PRE;
            mode_q       <= bpsk_mode;
            samp_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            busy_q       <= 1'b1;
            sym_strobe_q <= 1'b1;
            dac_i_q      <= c_pos;
            dac_q_q      <= bpsk_mode ? '0 : c_pos;
          end
        end
        S_PRE, S_DATA: begin
          if (!w_boundary) begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end else begin
            samp_cnt_q <= '0;
            if (bit_ready) begin
              pre_cnt_q <= '0;
              if (bit_valid) begin
                state_q      <= S_DATA;
                sym_strobe_q <= 1'b1;
                dac_i_q      <= mode_q ? map_bit(bit_data[0]) : map_bit(bit_data[1]);
                dac_q_q      <= mode_q ? '0 : map_bit(bit_data[0]);
              end else begin
                // Underrun or empty burst: drop straight back to silence.
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                dac_i_q   <= '0;
                dac_q_q   <= '0;
                is_bpsk_q <= bpsk_mode;
              end
            end else begin
              pre_cnt_q    <= pre_cnt_q + 1'b1;
              sym_strobe_q <= 1'b1;
              dac_i_q      <= w_next_pre;
              dac_q_q      <= mode_q ? '0 : w_next_pre;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DAC_I      = dac_i_q;
  assign DAC_Q      = dac_q_q;
  assign is_bpsk    = is_bpsk_q;
  assign sym_strobe = sym_strobe_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_psk_symbol_mapper.sv
// tb_psk_symbol_mapper: randomized bursts checked against a sample-stream reference model.
// Rev 1.0
`default_nettype none

module tb_psk_symbol_mapper;

  localparam int O_WIDTH = 12;
  localparam int AMP     = 1024;
  localparam int SPS     = 4;
  localparam int PRE_LEN = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [1:0]                bit_data;
  logic                      bit_valid;
  logic                      bit_ready;
  logic                      bpsk_mode;
  logic signed [O_WIDTH-1:0] dac_i;
  logic signed [O_WIDTH-1:0] dac_q;
  logic                      is_bpsk;
  logic                      sym_strobe;
  logic                      busy;

  int         n_pass  = 0;
  int         n_total = 0;
  logic       prev_mode;
  logic [1:0] syms[$];
  int         hs;

  always #5 clk = ~clk;

  psk_symbol_mapper #(
    .O_WIDTH (O_WIDTH),
    .AMP     (AMP),
    .SPS     (SPS),
    .PRE_LEN (PRE_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_data   (bit_data),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bpsk_mode  (bpsk_mode),
    .DAC_I      (dac_i),
    .DAC_Q      (dac_q),
    .is_bpsk    (is_bpsk),
    .sym_strobe (sym_strobe),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int lvl(input logic b);
    return AMP * (1 - 2 * int'(b));
  endfunction

  // Expected sample t of a burst: PRE_LEN alternating preamble symbols, then the data list.
  function automatic int ref_sample(input logic mode, input int t, input logic want_q);
    int s;
    int p;
    logic [1:0] d;
    s = t / SPS;
    if (s < PRE_LEN) begin
      p = (s % 2 == 0) ? AMP : -AMP;
      return (want_q && mode) ? 0 : p;
    end
    d = syms[s - PRE_LEN];
    if (mode) return want_q ? 0 : lvl(d[0]);
    return want_q ? lvl(d[0]) : lvl(d[1]);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_dac_i"},   dac_i, 0);
    chk({tag, "_dac_q"},   dac_q, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_strobe"},  sym_strobe, 0);
    chk({tag, "_ready"},   bit_ready, 0);
    chk({tag, "_is_bpsk"}, is_bpsk, prev_mode);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check_idle(tag);
    bit_valid = 1'b0;
    bit_data  = 2'($urandom);
    bpsk_mode = 1'($urandom);
    prev_mode = bpsk_mode;
  endtask

  task automatic run_burst(input logic mode, input string name);
    int n;
    int total;
    int nxt;
    logic ready_exp;
    n     = syms.size();
    total = SPS * (PRE_LEN + n);
    nxt   = 0;
    hs    = 0;
    @(negedge clk);
    check_idle({name, "_idle"});
    bit_valid = 1'b1;
    bpsk_mode = mode;
    bit_data  = 2'($urandom);
    prev_mode = mode;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      ready_exp = ((t % SPS) == SPS - 1) && ((t / SPS) >= PRE_LEN - 1);
      chk({name, "_i"},       dac_i, ref_sample(mode, t, 1'b0));
      chk({name, "_q"},       dac_q, ref_sample(mode, t, 1'b1));
      chk({name, "_strobe"},  sym_strobe, ((t % SPS) == 0) ? 1 : 0);
      chk({name, "_busy"},    busy, 1);
      chk({name, "_is_bpsk"}, is_bpsk, mode);
      chk({name, "_ready"},   bit_ready, ready_exp);
      bpsk_mode = 1'($urandom);
      prev_mode = bpsk_mode;
      if (ready_exp) begin
        if (nxt < n) begin
          bit_valid = 1'b1;
          bit_data  = syms[nxt];
          nxt++;
        end else begin
          bit_valid = 1'b0;
          bit_data  = 2'($urandom);
        end
      end else begin
        bit_valid = 1'($urandom);
        bit_data  = 2'($urandom);
      end
      if (bit_valid && bit_ready) hs++;
    end
    chk({name, "_handshakes"}, hs, n);
  endtask

  initial begin
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    bit_data  = 2'b00;
    bpsk_mode = 1'b1;
    #1 rst_n  = 1'b0;
    #7;
    chk("rst_dac_i",   dac_i, 0);
    chk("rst_dac_q",   dac_q, 0);
    chk("rst_is_bpsk", is_bpsk, 1);
    chk("rst_strobe",  sym_strobe, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_ready",   bit_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    prev_mode = bpsk_mode;
    idle_cycle("idle0");

    syms = '{2'b10, 2'b01, 2'b11};
    run_burst(1'b1, "bpsk3");

    syms = '{2'b10, 2'b01};
    run_burst(1'b0, "qpsk2");
    idle_cycle("gap1");

    syms = '{2'b11};
    run_burst(1'($urandom), "underrun");
    idle_cycle("gap2");

    syms = {};
    for (int k = 0; k < 10; k++) syms.push_back(2'($urandom));
    run_burst(1'b0, "backpr10");

    syms = '{2'b01, 2'b00, 2'b11, 2'b10};
    run_burst(1'b1, "modehold");
    syms = '{2'b01, 2'b10};
    run_burst(1'b0, "modenext");
    idle_cycle("gap3");

    @(negedge clk);
    check_idle("prerst_idle");
    bit_valid = 1'b1;
    bpsk_mode = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("prerst_i", dac_i, AMP);
      chk("prerst_q", dac_q, AMP);
      bit_valid = 1'($urandom);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dac_i",   dac_i, 0);
    chk("async_dac_q",   dac_q, 0);
    chk("async_busy",    busy, 0);
    chk("async_strobe",  sym_strobe, 0);
    chk("async_is_bpsk", is_bpsk, 1);
    chk("async_ready",   bit_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    prev_mode = bpsk_mode;
    idle_cycle("postrst");

    for (int b = 0; b < 8; b++) begin
      int n_sym;
      int gap;
      n_sym = int'($urandom_range(1, 6));
      gap   = int'($urandom_range(0, 3));
      syms  = {};
      for (int k = 0; k < n_sym; k++) syms.push_back(2'($urandom));
      run_burst(1'($urandom), "rand");
      for (int g = 0; g < gap; g++) idle_cycle("rand_gap");
    end
    idle_cycle("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/psk_symbol_mapper.md
Name: psk_symbol_mapper

Overview:
Upstream stage of the PSK transmit path. It accepts data bits over a valid/ready handshake, prepends a fixed preamble to each burst, maps bits to BPSK or QPSK I/Q levels, and holds each symbol for SPS samples. Its outputs are DAC_I, DAC_Q and is_bpsk, which drive the signal-extend stage directly.

Parameters:
O_WIDTH, 12, signed sample width of DAC_I/DAC_Q.
AMP, 1024, symbol magnitude; must satisfy 0 < AMP <= 2^(O_WIDTH-1)-1.
SPS, 16, samples per symbol, >= 2.
PRE_LEN, 8, preamble length in symbols, >= 1.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
bit_data  in  2  symbol bits; BPSK uses [0] only, QPSK uses [1]=I and [0]=Q.
bit_valid  in  1  bit_data valid.
bit_ready  out  1  symbol accepted when bit_valid && bit_ready.
bpsk_mode  in  1  1 = BPSK, 0 = QPSK; sampled at burst start.
DAC_I  out  O_WIDTH  signed I sample.
DAC_Q  out  O_WIDTH  signed Q sample.
is_bpsk  out  1  mode of the current output samples.
sym_strobe  out  1  high on the first sample of every symbol.
busy  out  1  high in PREAMBLE or DATA.

Behaviour:
- Reset values: DAC_I=0, DAC_Q=0, is_bpsk=1, sym_strobe=0, busy=0. State is IDLE and all counters are 0.
- Reset is asynchronous and applies immediately, including mid-burst. No partial symbol is completed.
- All outputs are registered except bit_ready, which is combinational from state and counters.
- Counters: samp_cnt runs 0..SPS-1 and wraps to 0. pre_cnt runs 0..PRE_LEN-1.
- "Boundary" means samp_cnt == SPS-1.
- Mapping: a bit value of 0 maps to +AMP and 1 maps to -AMP.
  - BPSK: DAC_I = map(bit_data[0]), DAC_Q = 0.
  - QPSK: DAC_I = map(bit_data[1]), DAC_Q = map(bit_data[0]).
- State IDLE:
  - DAC_I/DAC_Q are 0, bit_ready=0, is_bpsk follows bpsk_mode registered.
  - On bit_valid=1, latch mode_r=bpsk_mode and enter PREAMBLE. The data word is not consumed.
  - The first preamble sample appears on the next cycle with sym_strobe=1.
- State PREAMBLE:
  - Symbol k (k = pre_cnt) is +AMP if k is even and -AMP if odd.
  - BPSK drives I only with Q=0. QPSK drives I and Q with the same value.
  - pre_cnt increments at each boundary.
  - At the boundary of the last preamble symbol, bit_ready=1:
    - bit_valid=1: load the symbol and enter DATA; it is output the next cycle.
    - bit_valid=0: enter IDLE; outputs are 0 the next cycle.
- State DATA:
  - The symbol is held for SPS cycles.
  - At each boundary, bit_ready=1:
    - bit_valid=1: the next symbol is loaded and output the next cycle, with sym_strobe=1.
    - bit_valid=0 (underrun): burst ends and the block enters IDLE.
  - bit_ready=0 at all non-boundary cycles. Data offered off-boundary waits.
- Mode:
  - is_bpsk = mode_r throughout PREAMBLE and DATA.
  - bpsk_mode changes mid-burst are ignored until the next IDLE exit.
- A new burst always restarts the preamble with pre_cnt=0 and samp_cnt=0.
- busy is registered and high exactly while the state is PREAMBLE or DATA.
- Latency: a symbol accepted at a boundary edge appears on DAC_I/DAC_Q one cycle later.
- Burst length in cycles = SPS*(PRE_LEN + number of accepted symbols).

Test Plan:
1. BPSK burst, SPS=4, PRE_LEN=2, AMP=1024, bits 0,1,1 held valid.
   - Required: DAC_I = +1024 x4, -1024 x4, +1024 x4, -1024 x4, -1024 x4, then 0.
   - DAC_Q=0 throughout; is_bpsk=1; sym_strobe pulses 5 times; busy high for 20 cycles.
2. QPSK, bit_data=2'b10 then 2'b01 → I=-1024/Q=+1024 for SPS cycles, then I=+1024/Q=-1024; is_bpsk=0.
3. Underrun: valid dropped before the 2nd data boundary → exactly one data symbol output; outputs 0 and busy=0 one cycle after that boundary.
4. Backpressure: bit_valid held high for 10 symbols → bit_ready high only at samp_cnt==SPS-1; exactly 10 handshakes; no symbol skipped or duplicated.
5. Mode toggled mid-DATA from BPSK to QPSK → is_bpsk stays 1 and DAC_Q stays 0 until IDLE; the next burst uses QPSK.
6. rst_n asserted mid-symbol → DAC_I/DAC_Q/busy go to 0 asynchronously before the next clk edge; after release, IDLE with bit_ready=0.
